playback_scheduler: RTL and testbench

Sequences the flash audio read path. Decodes keyboard commands into play, pause, direction and restart controls. Generates the sample-rate strobe that paces each audio half-word fetch, with run-time speed adjustment. Sits between the keyboard decoder and the address-calculation/flash-control datapath, and replaces the free-running fixed 22 kHz clock with a gated, programmable strobe.

---
 rtl/playback_scheduler_if.sv | 25 ++
 rtl/playback_scheduler.sv | 139 +++++++++++++
 tb/tb_playback_scheduler.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/playback_scheduler_if.sv
// Command/strobe bundle between keyboard decoder, scheduler and address datapath.
// The scheduler sits on the slave modport; the driving environment uses master.
interface playback_scheduler_if;
  logic        key_valid;
  logic [7:0]  key_code;
  logic        speed_up;
  logic        speed_down;
  logic        speed_reset;
  logic        restart_ack;
  logic        play;
  logic        forward;
  logic        sample_tick;
  logic        restart_req;
  logic [13:0] divider;

  modport slave (
    input  key_valid, key_code, speed_up, speed_down, speed_reset, restart_ack,
    output play, forward, sample_tick, restart_req, divider
  );

  modport master (
    output key_valid, key_code, speed_up, speed_down, speed_reset, restart_ack,
    input  play, forward, sample_tick, restart_req, divider
  );
endinterface

// File: rtl/playback_scheduler.sv
// Play/pause/restart sequencer plus programmable sample-rate strobe; keys act one cycle later,
// first tick lands divider clocks after play rises; no backpressure, restart_req holds until ack.
module playback_scheduler #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BASE_RATE = 22000,
  parameter int DIV_STEP  = 64,
  parameter int DIV_MIN   = 568,
  parameter int DIV_MAX   = 9088
) (
  input logic                  clk,
  input logic                  rst_n,
  playback_scheduler_if.slave  bus
);

  localparam logic [13:0] DIV_DEF  = 14'(CLK_FREQ / BASE_RATE);
  localparam logic [13:0] STEP     = 14'(DIV_STEP);
  localparam logic [13:0] LIM_MIN  = 14'(DIV_MIN);
  localparam logic [13:0] LIM_MAX  = 14'(DIV_MAX);

  typedef enum logic [1:0] {PAUSED, PLAYING, RESTART} state_t;

  state_t      state_q, state_d;
  logic        resume_q, resume_d;
  logic        forward_q, forward_d;
  logic        tick_q, tick_d;
  logic [13:0] cnt_q, cnt_d;
  logic [13:0] pending_q, pending_d;
  logic [13:0] active_q, active_d;

  logic [7:0] key_uc;
  logic       key_e, key_d, key_f, key_b, key_r;
  logic       terminal;

  // Folding bit 5 makes letter matching case-insensitive.
  assign key_uc = bus.key_code & 8'hDF;
  assign key_e  = bus.key_valid && (key_uc == 8'h45);
  assign key_d  = bus.key_valid && (key_uc == 8'h44);
  assign key_f  = bus.key_valid && (key_uc == 8'h46);
  assign key_b  = bus.key_valid && (key_uc == 8'h42);
  assign key_r  = bus.key_valid && (key_uc == 8'h52);

  assign terminal = (cnt_q == active_q - 14'd1);

  always_comb begin
    state_d   = state_q;
    resume_d  = resume_q;
    forward_d = forward_q;
    pending_d = pending_q;
    active_d  = active_q;
    cnt_d     = '0;
    tick_d    = 1'b0;

    if (key_f) begin
      forward_d = 1'b1;
    end else if (key_b) begin
      forward_d = 1'b0;
    end

    case (state_q)
      PAUSED: begin
        if (key_e) begin
          state_d = PLAYING;
        end else if (key_r) begin
          state_d  = RESTART;
          resume_d = 1'b0;
        end
      end
      PLAYING: begin
        if (key_d) begin
          state_d = PAUSED;
        end else if (key_r) begin
          state_d  = RESTART;
          resume_d = 1'b1;
        end
      end
      RESTART: begin
        if (key_e) begin
          resume_d = 1'b1;
        end else if (key_d) begin
          resume_d = 1'b0;
        end
        if (bus.restart_ack) begin
          state_d = resume_d ? PLAYING : PAUSED;
        end
      end
      default: state_d = PAUSED;
    endcase

    // A terminal count that coincides with leaving PLAYING produces no tick.
    if (state_q == PLAYING && state_d == PLAYING) begin
      if (terminal) begin
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 14'd1;
      end
    end

    // Saturation is tested before the step so the register never wraps.
    if (bus.speed_reset) begin
      pending_d = DIV_DEF;
    end else if (bus.speed_up && !bus.speed_down) begin
      pending_d = (pending_q < LIM_MIN + STEP) ? LIM_MIN : pending_q - STEP;
    end else if (bus.speed_down && !bus.speed_up) begin
      pending_d = (pending_q > LIM_MAX - STEP) ? LIM_MAX : pending_q + STEP;
    end

    // Running periods are never resized; a new divider takes effect at the wrap.
    if (state_q != PLAYING || terminal) begin
      active_d = pending_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= PAUSED;
      resume_q  <= 1'b0;
      forward_q <= 1'b1;
      tick_q    <= 1'b0;
      cnt_q     <= '0;
      pending_q <= DIV_DEF;
      active_q  <= DIV_DEF;
    end else begin
      state_q   <= state_d;
      resume_q  <= resume_d;
      forward_q <= forward_d;
      tick_q    <= tick_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      active_q  <= active_d;
    end
  end

  assign bus.play        = (state_q == PLAYING);
  assign bus.restart_req = (state_q == RESTART);
  assign bus.forward     = forward_q;
  assign bus.sample_tick = tick_q;
  assign bus.divider     = active_q;

endmodule

// File: tb/tb_playback_scheduler.sv
// Directed bench: stimulus pushes expected sample_tick cycles into a scoreboard queue,
// an independent negedge monitor pops and compares each tick; levels are checked inline.
module tb_playback_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   exp_q[$];

  playback_scheduler_if bus ();

  playback_scheduler u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every observed tick must match the oldest expected cycle.
  always @(negedge clk) begin
    if (bus.sample_tick === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_tick: got tick at cycle %0d, expected none", cyc);
      end else begin
        check("tick_time", cyc, exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_n(input int n);
    repeat (n) step();
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) step();
  endtask

  task automatic key(input logic [7:0] c);
    bus.key_valid = 1'b1;
    bus.key_code  = c;
    step();
    bus.key_valid = 1'b0;
    bus.key_code  = 8'h00;
  endtask

  task automatic speed(input logic up, input logic dn, input logic rs);
    bus.speed_up    = up;
    bus.speed_down  = dn;
    bus.speed_reset = rs;
    step();
    bus.speed_up    = 1'b0;
    bus.speed_down  = 1'b0;
    bus.speed_reset = 1'b0;
  endtask

  task automatic ack();
    bus.restart_ack = 1'b1;
    step();
    bus.restart_ack = 1'b0;
  endtask

  initial begin
    int t0, t1, t3;
    bus.key_valid   = 1'b0;
    bus.key_code    = 8'h00;
    bus.speed_up    = 1'b0;
    bus.speed_down  = 1'b0;
    bus.speed_reset = 1'b0;
    bus.restart_ack = 1'b0;

    wait_n(3);
    check("rst_play", int'(bus.play), 0);
    check("rst_forward", int'(bus.forward), 1);
    check("rst_tick", int'(bus.sample_tick), 0);
    check("rst_req", int'(bus.restart_req), 0);
    check("rst_divider", int'(bus.divider), 2272);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Play and steady ticking at the default divider.
    key("E");
    t0 = cyc;
    check("play_on", int'(bus.play), 1);
    check("fwd_play", int'(bus.forward), 1);
    exp_q.push_back(t0 + 2272);
    exp_q.push_back(t0 + 4544);
    exp_q.push_back(t0 + 6816);

    // Pause at counter 1000, stay idle, resume (lowercase keys).
    wait_until(t0 + 7816);
    key("d");
    check("pause_play", int'(bus.play), 0);
    wait_n(3000);
    key("e");
    t1 = cyc;
    check("resume_play", int'(bus.play), 1);
    exp_q.push_back(t1 + 2272);
    exp_q.push_back(t1 + 4544);

    // Speed change mid-period: current period keeps 2272, next is 2208.
    wait_until(t1 + 5044);
    speed(1'b1, 1'b0, 1'b0);
    check("div_hold_mid", int'(bus.divider), 2272);
    exp_q.push_back(t1 + 6816);
    exp_q.push_back(t1 + 9024);
    wait_until(t1 + 6817);
    check("div_after_wrap", int'(bus.divider), 2208);
    wait_until(t1 + 9030);
    key("D");
    check("pause2_play", int'(bus.play), 0);

    // Divider saturation while paused.
    speed(1'b0, 1'b0, 1'b1);
    check("div_reset", int'(bus.divider), 2272);
    repeat (26) speed(1'b1, 1'b0, 1'b0);
    check("div_up26", int'(bus.divider), 608);
    repeat (14) speed(1'b1, 1'b0, 1'b0);
    check("div_min_sat", int'(bus.divider), 568);
    speed(1'b0, 1'b0, 1'b1);
    repeat (106) speed(1'b0, 1'b1, 1'b0);
    check("div_dn106", int'(bus.divider), 9056);
    repeat (24) speed(1'b0, 1'b1, 1'b0);
    check("div_max_sat", int'(bus.divider), 9088);
    speed(1'b1, 1'b1, 1'b0);
    check("div_both", int'(bus.divider), 9088);
    speed(1'b1, 1'b0, 1'b0);
    check("div_from_max", int'(bus.divider), 9024);
    speed(1'b1, 1'b1, 1'b1);
    check("div_reset2", int'(bus.divider), 2272);

    // Restart from PLAYING resumes playback.
    key("E");
    key("R");
    check("rs_play", int'(bus.play), 0);
    check("rs_req", int'(bus.restart_req), 1);
    wait_n(50);
    check("rs_req_held", int'(bus.restart_req), 1);
    key("b");
    check("rs_fwd_b", int'(bus.forward), 0);
    key("R");
    check("rs_req_rr", int'(bus.restart_req), 1);
    ack();
    t3 = cyc;
    check("rs_ack_req", int'(bus.restart_req), 0);
    check("rs_ack_play", int'(bus.play), 1);
    check("rs_fwd_keep", int'(bus.forward), 0);
    exp_q.push_back(t3 + 2272);
    wait_until(t3 + 2300);
    key("D");
    key("F");
    check("fwd_f", int'(bus.forward), 1);

    // Restart from PAUSED; E then D inside RESTART leaves it paused.
    key("r");
    check("rp_req", int'(bus.restart_req), 1);
    key("E");
    check("rp_e_nostate", int'(bus.play), 0);
    key("D");
    wait_n(20);
    ack();
    check("rp_ack_req", int'(bus.restart_req), 0);
    check("rp_ack_play", int'(bus.play), 0);
    ack();
    check("stray_ack_play", int'(bus.play), 0);
    check("stray_ack_req", int'(bus.restart_req), 0);

    // Asynchronous reset during RESTART.
    speed(1'b1, 1'b0, 1'b0);
    check("pre_rst_div", int'(bus.divider), 2208);
    key("B");
    key("E");
    key("R");
    #2 rst_n = 1'b0;
    #1;
    check("arst_req", int'(bus.restart_req), 0);
    check("arst_play", int'(bus.play), 0);
    check("arst_fwd", int'(bus.forward), 1);
    check("arst_div", int'(bus.divider), 2272);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Asynchronous reset during PLAYING.
    key("E");
    wait_n(100);
    #2 rst_n = 1'b0;
    #1;
    check("arst2_play", int'(bus.play), 0);
    check("arst2_tick", int'(bus.sample_tick), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Unknown keys do nothing.
    key("X");
    check("x_play", int'(bus.play), 0);
    check("x_fwd", int'(bus.forward), 1);
    check("x_req", int'(bus.restart_req), 0);
    key("E");
    key("x");
    check("x_playing", int'(bus.play), 1);
    key("D");
    wait_n(10);
    check("sb_drain", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
